// File: rtl/lsu_mem_ctrl_if.sv
// Request/response channel between MEM stage and LSU,
// and the word-wide data memory bus.
interface lsu_req_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [1:0]            req_size;
  logic                  req_sign;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_size, req_sign,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_size, req_sign,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [1:0]            mem_size;
  logic                  mem_sign;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_we, mem_addr, mem_wdata,
    output mem_size, mem_sign,
    input  mem_rdata
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata,
    input  mem_size, mem_sign,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one request at a time,
// word-granular memory, read-modify-write sub-word stores.
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  typedef enum logic [2:0] {
    IDLE, LOAD, READ, WRITE, RESP
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic                  req_err;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  assign req.req_ready  = (state_q == IDLE) && !rst;
  assign req.resp_valid = resp_valid_q;
  assign req.resp_rdata = resp_rdata_q;
  assign req.resp_err   = resp_err_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wdata  = mem_wdata_q;
  assign mem.mem_size   = 2'b10;
  assign mem.mem_sign   = 1'b0;

  // Range check treats every access as a full aligned word
  always_comb begin
    req_err = (req.req_size == 2'b11)
      || (req.req_size == 2'b01 && req.req_addr[0])
      || (req.req_size == 2'b10 && req.req_addr[1:0] != 2'b00)
      || (req.req_addr > ADDR_WIDTH'(MEM_BYTES - 4));
  end

  always_comb begin
    lane_b = mem.mem_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? mem.mem_rdata[31:16]
                      : mem.mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{sign_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{sign_q & lane_h[15]}}, lane_h};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem.mem_rdata;
    if (size_q == 2'b00)
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    sign_d       = sign_q;
    wdata_d      = wdata_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          off_d        = req.req_addr[1:0];
          size_d       = req.req_size;
          sign_d       = req.req_sign;
          wdata_d      = req.req_wdata[15:0];
          mem_addr_d   = {req.req_addr[ADDR_WIDTH-1:2], 2'b00};
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req.req_we) begin
            state_d = LOAD;
          end else if (req.req_size == 2'b10) begin
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_wdata_d = req.req_wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      LOAD: begin
        resp_rdata_d = load_ext;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      READ: begin
        mem_wdata_d = merged;
        mem_we_d    = 1'b1;
        state_d     = WRITE;
      end
      WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (req.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      off_q        <= '0;
      size_q       <= '0;
      sign_q       <= 1'b0;
      wdata_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      wdata_q      <= wdata_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller between the pipeline MEM stage and the byte-addressed data memory. Accepts one request at a time over a valid/ready handshake, checks alignment and range, and issues word-granular accesses to the memory. Sub-word stores are done as read-modify-write because the memory writes all four bytes on every write. Returns load data (lane-extracted, sign- or zero-extended) or an error on a valid/ready response channel.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width (fixed at 32)
- MEM_BYTES, 4096, memory size in bytes; accesses at or beyond it are errors
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 store, 0 load
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_sign  in  1  load sign-extend (1) or zero-extend (0)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  DATA_WIDTH  load result; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal size
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  DATA_WIDTH  full word to write
- mem_size  out  2  constant 2'b10
- mem_sign  out  1  constant 0
- mem_rdata  in  DATA_WIDTH  combinational read word at mem_addr

## Operation
- States: IDLE, LOAD, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/wdata/size/sign.
- Error check at accept: size==11; half with addr[0]=1; word with addr[1:0]!=0; addr>MEM_BYTES-4 (aligned word). Error -> RESP with resp_err=1, resp_rdata=0. Memory is never written.
- Load -> LOAD: mem_addr driven; capture mem_rdata at end of cycle; extract lane (byte lane addr[1:0], half lane addr[1]); extend per sign; -> RESP.
- Word store -> WRITE: mem_we=1, mem_wdata=wdata -> RESP.
- Byte/half store -> READ: capture mem_rdata as old word -> WRITE: mem_wdata = old word with the selected lane replaced by wdata[7:0] or wdata[15:0]; mem_we=1 -> RESP.
- RESP: resp_valid=1 with stable rdata/err until resp_ready; then -> IDLE. req_ready=0 in every state but IDLE.
- mem_we high only in WRITE, exactly one cycle per store.

## Timing
- Cycle 0 = accept cycle. resp_valid first high: error cycle 1; load cycle 2; word store cycle 2; sub-word store cycle 3.
- Back-to-back: next request accepted no earlier than the cycle after the resp handshake (IDLE cycle).
- mem_addr holds the last captured aligned address outside active states.
- Reset values: req_ready=0 while rst high, 1 in the first cycle after release; resp_valid=0; resp_rdata=0; resp_err=0; mem_we=0; mem_addr=0; mem_wdata=0; state IDLE.
- rst during any state: mem_we drops immediately (async); the in-flight request is dropped without a response; a pending RMW performs no write.
- resp_ready ignored outside RESP. req fields ignored when not accepted.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_we one cycle with mem_addr=0x10; load resp at cycle 2, rdata=0xDEADBEEF, err=0.
- Byte store 0x5A @0x13 over 0x11223344 -> READ then WRITE with mem_wdata=0x5A223344; signed byte load @0x13 -> 0x0000005A; word @0x10 -> 0x5A223344.
- Half loads @0x12 of 0x8001xxxx: sign=1 -> 0xFFFF8001, sign=0 -> 0x00008001.
- Word load @0x11, half store @0x13, size=11, and word load @0xFFC vs @0x1000 -> err=1 at cycle 1 for all but @0xFFC (valid); mem_we never asserted and memory unchanged.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata/err stable, req_ready=0, a new req_valid not accepted; accepted in the IDLE cycle after release.
- Assert rst in the WRITE cycle of a byte store -> mem_we falls at once, resp_valid=0, req_ready=1 in the first cycle after release.
